// File: rtl/axis_tx_pkt_gen_pkg.sv
// Shared definitions for the AXI-Stream TX frame generator.
// Covers state encodings, length limits, the LFSR tap mask and the strobe/clamp/LFSR helpers.
package axis_tx_pkt_gen_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_GAP  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    SEND = ST_SEND,
    GAP  = ST_GAP,
    DONE = ST_DONE
  } state_t;

  localparam logic [15:0] MIN_LEN   = 16'd60;
  localparam logic [15:0] MAX_LEN   = 16'd1514;
  localparam logic [15:0] ETHERTYPE = 16'h0800;

  // Galois right-shift mask for x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [15:0] clamp_len(input logic [15:0] len);
    if (len < MIN_LEN)      return MIN_LEN;
    else if (len > MAX_LEN) return MAX_LEN;
    else                    return len;
  endfunction

  function automatic logic [7:0] last_strb(input logic [2:0] rem);
    return (rem == 3'd0) ? 8'hFF : 8'((9'h001 << rem) - 9'h001);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/axis_tx_pkt_gen_if.sv
// TX client stream towards the LMAC (tx_axis_mac_*).
interface axis_tx_pkt_gen_if;
  logic [63:0] tx_axis_mac_tdata;
  logic        tx_axis_mac_tvalid;
  logic        tx_axis_mac_tlast;
  logic        tx_axis_mac_tuser;
  logic [7:0]  tx_axis_mac_tstrb;
  logic        tx_axis_mac_tready;

  modport master (
    output tx_axis_mac_tdata, tx_axis_mac_tvalid, tx_axis_mac_tlast,
    output tx_axis_mac_tuser, tx_axis_mac_tstrb,
    input  tx_axis_mac_tready
  );

  modport slave (
    input  tx_axis_mac_tdata, tx_axis_mac_tvalid, tx_axis_mac_tlast,
    input  tx_axis_mac_tuser, tx_axis_mac_tstrb,
    output tx_axis_mac_tready
  );
endinterface

// File: rtl/axis_tx_pkt_gen_lfsr32.sv
// lmac_lfsr32: 32-bit payload LFSR; presents two consecutive states and steps by two per enable.
module lmac_lfsr32
  import axis_tx_pkt_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [31:0] seed,
  output logic [31:0] word_lo,
  output logic [31:0] word_hi
);

  logic [31:0] lfsr_q, lfsr_d;

  assign word_lo = lfsr_q;
  assign word_hi = lfsr_step(lfsr_q);

  // All-zero state would lock the register, so a zero seed maps to 1
  always_comb begin
    lfsr_d = lfsr_q;
    if (load)    lfsr_d = (seed == '0) ? 32'h1 : seed;
    else if (en) lfsr_d = lfsr_step(word_hi);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 32'h1;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/axis_tx_pkt_gen.sv
// AXI-Stream frame generator for the LMAC TX client port.
// Define AXIS_PKT_GEN_LFSR_EN for LFSR payload; otherwise payload is a seeded beat counter.
module axis_tx_pkt_gen
  import axis_tx_pkt_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned IFG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  gen_en_wr,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_len,
  input  logic [LEN_WIDTH-1:0]  cfg_pkt_cnt,
  input  logic [IFG_WIDTH-1:0]  cfg_ifg,
  input  logic [31:0]           cfg_seed,
  axis_tx_pkt_gen_if.master     tx,
  output logic                  gen_busy,
  output logic                  gen_done,
  output logic [31:0]           pkt_sent_cnt
);

  state_t                 state_q, state_d;
  logic                   en_q;
  logic [LEN_WIDTH-1:0]   last_idx_q, last_idx_d;
  logic [2:0]             rem_q, rem_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic [IFG_WIDTH-1:0]   ifg_q, ifg_d;
  logic [IFG_WIDTH-1:0]   gap_q, gap_d;
  logic [31:0]            seed_q, seed_d;
  logic [LEN_WIDTH-1:0]   beat_q, beat_d;
  logic [LEN_WIDTH-1:0]   seq_q, seq_d;
  logic [31:0]            sent_q, sent_d;
  logic [15:0]            len_c;

  logic                   send;
  logic                   is_last;
  logic [7:0]             strb;
  logic [DATA_WIDTH-1:0]  byte_mask;
  logic [DATA_WIDTH-1:0]  payload;
  logic [DATA_WIDTH-1:0]  raw;

  assign send    = (state_q == SEND);
  assign is_last = (beat_q == last_idx_q);

`ifdef AXIS_PKT_GEN_LFSR_EN
  logic [31:0] lfsr_lo, lfsr_hi;

  lmac_lfsr32 u_lfsr (
    .clk     (clk),
    .rst_n   (reset_),
    .load    (state_q == LOAD),
    .en      (send && tx.tx_axis_mac_tready && (beat_q != '0)),
    .seed    (cfg_seed),
    .word_lo (lfsr_lo),
    .word_hi (lfsr_hi)
  );

  assign payload = {lfsr_hi, lfsr_lo};
`else
  logic [31:0] word;

  assign word    = seed_q + 32'(beat_q);
  assign payload = {word, word};
`endif

  always_comb begin
    state_d    = state_q;
    last_idx_d = last_idx_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    ifg_d      = ifg_q;
    gap_d      = gap_q;
    seed_d     = seed_q;
    beat_d     = beat_q;
    seq_d      = seq_q;
    sent_d     = sent_q;
    len_c      = clamp_len(cfg_pkt_len);
    unique case (state_q)
      IDLE: if (gen_en_wr && !en_q) state_d = LOAD;
      LOAD: begin
        last_idx_d = ((len_c + 16'd7) >> 3) - 16'd1;
        rem_d      = len_c[2:0];
        cnt_d      = cfg_pkt_cnt;
        ifg_d      = cfg_ifg;
        seed_d     = cfg_seed;
        beat_d     = '0;
        seq_d      = '0;
        state_d    = SEND;
      end
      SEND: if (tx.tx_axis_mac_tready) begin
        if (is_last) begin
          beat_d = '0;
          seq_d  = seq_q + 1'b1;
          sent_d = sent_q + 1'b1;
          // Run completion wins over enable drop, which wins over the gap
          if ((cnt_q != '0) && (seq_d == cnt_q)) state_d = DONE;
          else if (!gen_en_wr)                   state_d = IDLE;
          else if (ifg_q != '0) begin
            state_d = GAP;
            gap_d   = ifg_q;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      GAP: begin
        if (!gen_en_wr)                     state_d = IDLE;
        else if (gap_q == IFG_WIDTH'(1))    state_d = SEND;
        else                                gap_d   = gap_q - 1'b1;
      end
      DONE: if (!gen_en_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    strb = is_last ? last_strb(rem_q) : 8'hFF;
    for (int unsigned i = 0; i < 8; i++) byte_mask[i*8 +: 8] = {8{strb[i]}};
    raw = (beat_q == '0) ? {ETHERTYPE, seq_q[15:0], seed_q} : payload;
  end

  assign tx.tx_axis_mac_tvalid = send;
  assign tx.tx_axis_mac_tdata  = send ? (raw & byte_mask) : '0;
  assign tx.tx_axis_mac_tstrb  = send ? strb : '0;
  assign tx.tx_axis_mac_tlast  = send && is_last;
  assign tx.tx_axis_mac_tuser  = 1'b0;

  assign gen_busy     = (state_q == LOAD) || send || (state_q == GAP);
  assign gen_done     = (state_q == DONE);
  assign pkt_sent_cnt = sent_q;

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= IDLE;
      en_q       <= 1'b0;
      last_idx_q <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      ifg_q      <= '0;
      gap_q      <= '0;
      seed_q     <= '0;
      beat_q     <= '0;
      seq_q      <= '0;
      sent_q     <= '0;
    end else begin
      state_q    <= state_d;
      en_q       <= gen_en_wr;
      last_idx_q <= last_idx_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      ifg_q      <= ifg_d;
      gap_q      <= gap_d;
      seed_q     <= seed_d;
      beat_q     <= beat_d;
      seq_q      <= seq_d;
      sent_q     <= sent_d;
    end
  end

endmodule

// File: tb/tb_axis_tx_pkt_gen.sv
// Directed self-checking bench for axis_tx_pkt_gen (default counter-payload build).
module tb_axis_tx_pkt_gen;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        gen_en_wr = 1'b0;
  logic [15:0] cfg_pkt_len = '0;
  logic [15:0] cfg_pkt_cnt = '0;
  logic [7:0]  cfg_ifg = '0;
  logic [31:0] cfg_seed = '0;
  logic        gen_busy, gen_done;
  logic [31:0] pkt_sent_cnt;

  axis_tx_pkt_gen_if tx_if ();

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_sent = 0;
  int unsigned nb, pi;
  logic [63:0] cap_data [0:255];
  logic [7:0]  cap_strb [0:255];

  always #5 clk = ~clk;

  axis_tx_pkt_gen #(.DATA_WIDTH(64), .LEN_WIDTH(16), .IFG_WIDTH(8)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .gen_en_wr    (gen_en_wr),
    .cfg_pkt_len  (cfg_pkt_len),
    .cfg_pkt_cnt  (cfg_pkt_cnt),
    .cfg_ifg      (cfg_ifg),
    .cfg_seed     (cfg_seed),
    .tx           (tx_if),
    .gen_busy     (gen_busy),
    .gen_done     (gen_done),
    .pkt_sent_cnt (pkt_sent_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned clamp(input int unsigned len);
    if (len < 60)   return 60;
    if (len > 1514) return 1514;
    return len;
  endfunction

  function automatic logic [63:0] exp_data(input int unsigned k, input logic [15:0] seq,
                                           input logic [31:0] seed, input int unsigned len);
    int unsigned l    = clamp(len);
    int unsigned last = (l + 7) / 8 - 1;
    logic [31:0] w    = seed + 32'(k);
    logic [63:0] d    = (k == 0) ? {16'h0800, seq, seed} : {w, w};
    if (k == last && (l % 8) != 0)
      for (int unsigned i = l % 8; i < 8; i++) d[i*8 +: 8] = 8'h00;
    return d;
  endfunction

  function automatic logic [7:0] exp_strb(input int unsigned k, input int unsigned len);
    int unsigned l = clamp(len);
    if (k == (l + 7) / 8 - 1 && (l % 8) != 0) return 8'hFF >> (8 - (l % 8));
    return 8'hFF;
  endfunction

  task automatic start_run(input logic [15:0] len, input logic [15:0] cnt,
                           input logic [7:0] ifg, input logic [31:0] seed);
    @(negedge clk);
    cfg_pkt_len = len;
    cfg_pkt_cnt = cnt;
    cfg_ifg     = ifg;
    cfg_seed    = seed;
    gen_en_wr   = 1'b1;
  endtask

  task automatic stop_run();
    @(negedge clk);
    gen_en_wr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Follows one frame; every valid cycle (stalled or not) is compared with the beat expected next
  task automatic capture(input string tag, input logic [15:0] seq, input logic [31:0] seed,
                         input int unsigned len, input bit toggle, input int drop_at,
                         output int unsigned nbeats, output int unsigned pre_idle);
    bit          started  = 1'b0;
    bit          finished = 1'b0;
    int unsigned cyc      = 0;
    int unsigned last     = (clamp(len) + 7) / 8 - 1;
    nbeats   = 0;
    pre_idle = 0;
    while (!finished && cyc < 600) begin
      @(negedge clk);
      tx_if.tx_axis_mac_tready = toggle ? ((cyc % 2) == 0) : 1'b1;
      if (drop_at >= 0 && int'(nbeats) == drop_at) gen_en_wr = 1'b0;
      #1;
      if (tx_if.tx_axis_mac_tvalid) begin
        started = 1'b1;
        chk({tag, " tdata"}, tx_if.tx_axis_mac_tdata, exp_data(nbeats, seq, seed, len));
        chk({tag, " tstrb"}, 64'(tx_if.tx_axis_mac_tstrb), 64'(exp_strb(nbeats, len)));
        chk({tag, " tlast"}, 64'(tx_if.tx_axis_mac_tlast), 64'(nbeats == last));
        chk({tag, " tuser"}, 64'(tx_if.tx_axis_mac_tuser), 64'(1'b0));
        if (tx_if.tx_axis_mac_tready) begin
          cap_data[nbeats] = tx_if.tx_axis_mac_tdata;
          cap_strb[nbeats] = tx_if.tx_axis_mac_tstrb;
          nbeats++;
          if (tx_if.tx_axis_mac_tlast || nbeats > 255) finished = 1'b1;
        end
      end else if (!started) begin
        pre_idle++;
      end else begin
        chk({tag, " tvalid mid-frame"}, 64'(tx_if.tx_axis_mac_tvalid), 64'(1'b1));
      end
      cyc++;
    end
    chk({tag, " frame completed"}, 64'(finished), 64'(1'b1));
    tx_if.tx_axis_mac_tready = 1'b1;
  endtask

  initial begin
    bit reached;
    tx_if.tx_axis_mac_tready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst tvalid", 64'(tx_if.tx_axis_mac_tvalid), 64'(1'b0));
    chk("rst tdata", tx_if.tx_axis_mac_tdata, 64'h0);
    chk("rst tlast", 64'(tx_if.tx_axis_mac_tlast), 64'(1'b0));
    chk("rst tstrb", 64'(tx_if.tx_axis_mac_tstrb), 64'(8'h00));
    chk("rst tuser", 64'(tx_if.tx_axis_mac_tuser), 64'(1'b0));
    chk("rst busy", 64'(gen_busy), 64'(1'b0));
    chk("rst done", 64'(gen_done), 64'(1'b0));
    chk("rst sent", 64'(pkt_sent_cnt), 64'(32'd0));
    @(negedge clk);
    reset_ = 1'b1;

    // 1: single 64-byte frame
    start_run(16'd64, 16'd1, 8'd0, 32'hA000_0000);
    capture("t1", 16'd0, 32'hA000_0000, 64, 1'b0, -1, nb, pi);
    chk("t1 beats", 64'(nb), 64'(8));
    chk("t1 beat0", cap_data[0], 64'h0800_0000_A000_0000);
    chk("t1 beat7", cap_data[7], 64'hA000_0007_A000_0007);
    chk("t1 strb7", 64'(cap_strb[7]), 64'(8'hFF));
    exp_sent = 1;
    @(negedge clk); #1;
    chk("t1 done", 64'(gen_done), 64'(1'b1));
    chk("t1 busy", 64'(gen_busy), 64'(1'b0));
    chk("t1 tvalid", 64'(tx_if.tx_axis_mac_tvalid), 64'(1'b0));
    chk("t1 sent", 64'(pkt_sent_cnt), 64'(exp_sent));
    stop_run(); #1;
    chk("t1 done cleared", 64'(gen_done), 64'(1'b0));

    // 2a: 61 bytes, partial last beat
    start_run(16'd61, 16'd1, 8'd0, 32'h1234_5678);
    capture("t2a", 16'd0, 32'h1234_5678, 61, 1'b0, -1, nb, pi);
    chk("t2a beats", 64'(nb), 64'(8));
    chk("t2a strb7", 64'(cap_strb[7]), 64'(8'h1F));
    chk("t2a beat7", cap_data[7], 64'h0000_007F_1234_567F);
    exp_sent++;
    stop_run(); #1;
    chk("t2a sent", 64'(pkt_sent_cnt), 64'(exp_sent));

    // 2b: 20 bytes clamps to 60
    start_run(16'd20, 16'd1, 8'd0, 32'h0);
    capture("t2b", 16'd0, 32'h0, 20, 1'b0, -1, nb, pi);
    chk("t2b beats", 64'(nb), 64'(8));
    chk("t2b strb7", 64'(cap_strb[7]), 64'(8'h0F));
    chk("t2b beat7", cap_data[7], 64'h0000_0000_0000_0007);
    exp_sent++;
    stop_run();

    // 3: tready toggling
    start_run(16'd64, 16'd1, 8'd0, 32'h0000_0100);
    capture("t3", 16'd0, 32'h0000_0100, 64, 1'b1, -1, nb, pi);
    chk("t3 beats", 64'(nb), 64'(8));
    chk("t3 beat3", cap_data[3], 64'h0000_0103_0000_0103);
    exp_sent++;
    stop_run(); #1;
    chk("t3 sent", 64'(pkt_sent_cnt), 64'(exp_sent));

    // 4: three frames with a 5-cycle gap
    start_run(16'd60, 16'd3, 8'd5, 32'h0000_0005);
    capture("t4f0", 16'd0, 32'h5, 60, 1'b0, -1, nb, pi);
    chk("t4f0 beats", 64'(nb), 64'(8));
    capture("t4f1", 16'd1, 32'h5, 60, 1'b0, -1, nb, pi);
    chk("t4f1 gap", 64'(pi), 64'(5));
    chk("t4f1 beat0", cap_data[0], 64'h0800_0001_0000_0005);
    capture("t4f2", 16'd2, 32'h5, 60, 1'b0, -1, nb, pi);
    chk("t4f2 gap", 64'(pi), 64'(5));
    chk("t4f2 beat0", cap_data[0], 64'h0800_0002_0000_0005);
    exp_sent += 3;
    @(negedge clk); #1;
    chk("t4 done", 64'(gen_done), 64'(1'b1));
    chk("t4 sent", 64'(pkt_sent_cnt), 64'(exp_sent));
    stop_run();

    // 5: continuous run, enable dropped at beat 3 of the second frame
    start_run(16'd64, 16'd0, 8'd0, 32'h0000_0077);
    capture("t5f0", 16'd0, 32'h77, 64, 1'b0, -1, nb, pi);
    capture("t5f1", 16'd1, 32'h77, 64, 1'b0, 3, nb, pi);
    chk("t5f1 back-to-back", 64'(pi), 64'(0));
    chk("t5f1 beats", 64'(nb), 64'(8));
    exp_sent += 2;
    @(negedge clk); #1;
    chk("t5 busy", 64'(gen_busy), 64'(1'b0));
    chk("t5 done", 64'(gen_done), 64'(1'b0));
    repeat (4) @(negedge clk);
    #1;
    chk("t5 idle tvalid", 64'(tx_if.tx_axis_mac_tvalid), 64'(1'b0));
    chk("t5 sent", 64'(pkt_sent_cnt), 64'(exp_sent));

    // 6: reset asserted while beat 4 is on the bus
    start_run(16'd64, 16'd0, 8'd0, 32'hDEAD_0000);
    nb = 0;
    reached = 1'b0;
    for (int unsigned c = 0; c < 50 && !reached; c++) begin
      @(negedge clk); #1;
      if (tx_if.tx_axis_mac_tvalid && nb == 4) reached = 1'b1;
      else if (tx_if.tx_axis_mac_tvalid && tx_if.tx_axis_mac_tready) nb++;
    end
    chk("t6 reached beat4", 64'(reached), 64'(1'b1));
    reset_    = 1'b0;
    gen_en_wr = 1'b0;
    #1;
    chk("t6 rst tvalid", 64'(tx_if.tx_axis_mac_tvalid), 64'(1'b0));
    chk("t6 rst tdata", tx_if.tx_axis_mac_tdata, 64'h0);
    chk("t6 rst busy", 64'(gen_busy), 64'(1'b0));
    chk("t6 rst sent", 64'(pkt_sent_cnt), 64'(32'd0));
    @(negedge clk);
    reset_   = 1'b1;
    exp_sent = 0;
    start_run(16'd64, 16'd1, 8'd0, 32'hDEAD_0000);
    capture("t6", 16'd0, 32'hDEAD_0000, 64, 1'b0, -1, nb, pi);
    chk("t6 beat0", cap_data[0], 64'h0800_0000_DEAD_0000);
    exp_sent++;
    @(negedge clk); #1;
    chk("t6 sent", 64'(pkt_sent_cnt), 64'(exp_sent));
    chk("t6 done", 64'(gen_done), 64'(1'b1));
    stop_run();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
